// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage: data width, reset
// address, bubble encoding and the fetch FSM state type.
package if_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
  // addi x0,x0,0
  localparam logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013;

  // state   | meaning
  // ST_REQ  | imem_req high, presenting pc, waiting for gnt
  // ST_WAIT | one fetch accepted, waiting for rvalid
  // ST_HOLD | response parked in hold buffer until the stall releases
  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } if_state_e;

  // Sequential next PC; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] next_seq_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(4);
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// IF/ID pipeline register. Flush has priority over stall, and stall has
// priority over loading. When the register advances with nothing new to
// load, it takes a bubble and keeps its PC.
module if_id_reg
  import if_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_flush,
  input  logic            i_advance,
  input  logic            i_load,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_instr,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_instr,
  output logic            o_valid
);

  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_instr;
  logic            r_valid;

  // Register update: flush > hold > load > bubble.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc    <= '0;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_flush) begin
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
    end else if (i_advance) begin
      if (i_load) begin
        r_pc    <= i_pc;
        r_instr <= i_instr;
        r_valid <= 1'b1;
      end else begin
        r_instr <= NOP_INSTR;
        r_valid <= 1'b0;
      end
    end
  end

  assign o_pc    = r_pc;
  assign o_instr = r_instr;
  assign o_valid = r_valid;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage. It owns the PC and issues one fetch at a time
// over the imem request/grant/response handshake. A one-entry hold buffer
// parks a response that arrives during a load-use stall. A kill flag
// discards a response that is still in flight when a branch redirects.
module if_stage
  import if_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            hazard_detection_src,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] IF_ID_PC,
  output logic [XLEN-1:0] IF_ID_Instr,
  output logic            IF_ID_Valid
);

  if_state_e       r_state;
  if_state_e       w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] r_pend_pc;
  logic [XLEN-1:0] w_pend_pc_nxt;
  logic            r_kill;
  logic            w_kill_nxt;
  logic [XLEN-1:0] r_hold_pc;
  logic [XLEN-1:0] r_hold_instr;
  logic            w_hold_we;
  logic            w_ifid_load;
  logic [XLEN-1:0] w_ifid_pc;
  logic [XLEN-1:0] w_ifid_instr;

  // Fetch FSM next-state, PC and IF/ID load decode.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_pend_pc_nxt = r_pend_pc;
    w_kill_nxt    = r_kill;
    w_hold_we     = 1'b0;
    w_ifid_load   = 1'b0;
    w_ifid_pc     = r_pend_pc;
    w_ifid_instr  = imem_rdata;

    unique case (r_state)
      ST_REQ: begin
        if (imem_gnt) begin
          w_pend_pc_nxt = r_pc;
          w_pc_nxt      = next_seq_pc(r_pc);
          // A redirect in the grant cycle means the accepted fetch is wrong-path.
          w_kill_nxt    = branch_taken;
          w_state_nxt   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          w_kill_nxt  = 1'b0;
          w_state_nxt = ST_REQ;
          if (!r_kill && !branch_taken) begin
            if (hazard_detection_src) begin
              w_ifid_load = 1'b1;
            end else begin
              w_hold_we   = 1'b1;
              w_state_nxt = ST_HOLD;
            end
          end
        end else if (branch_taken) begin
          w_kill_nxt = 1'b1;
        end
      end
      ST_HOLD: begin
        w_ifid_pc    = r_hold_pc;
        w_ifid_instr = r_hold_instr;
        if (branch_taken) begin
          w_state_nxt = ST_REQ;
        end else if (hazard_detection_src) begin
          w_ifid_load = 1'b1;
          w_state_nxt = ST_REQ;
        end
      end
      default: begin
        w_state_nxt = ST_REQ;
        w_kill_nxt  = 1'b0;
      end
    endcase

    // A redirect always wins over the sequential PC, in every state.
    if (branch_taken) begin
      w_pc_nxt = branch_target;
    end
  end

  // FSM state, PC, pending-fetch PC and kill flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_REQ;
      r_pc      <= RESET_PC;
      r_pend_pc <= RESET_PC;
      r_kill    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_pend_pc <= w_pend_pc_nxt;
      r_kill    <= w_kill_nxt;
    end
  end

  // One-entry hold buffer for a response that arrives during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_pc    <= '0;
      r_hold_instr <= NOP_INSTR;
    end else if (w_hold_we) begin
      r_hold_pc    <= r_pend_pc;
      r_hold_instr <= imem_rdata;
    end
  end

  // The request is gated by rst_n so that it stays low while reset is held.
  assign imem_req  = (r_state == ST_REQ) && rst_n;
  assign imem_addr = r_pc;

  if_id_reg u_if_id_reg (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_flush   (branch_taken),
    .i_advance (hazard_detection_src),
    .i_load    (w_ifid_load),
    .i_pc      (w_ifid_pc),
    .i_instr   (w_ifid_instr),
    .o_pc      (IF_ID_PC),
    .o_instr   (IF_ID_Instr),
    .o_valid   (IF_ID_Valid)
  );

endmodule
